// File: rtl/mp_adder.sv
// mp_adder: multi-cycle 1027-bit add/subtract, one CHUNK_W-bit limb per clock.
// The carry ripples between limbs through a registered carry bit. The result
// is held stable from done until the next accepted start.
module mp_adder #(
    parameter int unsigned N_BITS  = 1027,
    parameter int unsigned CHUNK_W = 128
) (
    input  logic              clk,
    input  logic              resetn,     // synchronous, active-high
    input  logic              start,
    input  logic              subtract,
    input  logic [N_BITS-1:0] in_a,
    input  logic [N_BITS-1:0] in_b,
    output logic [N_BITS:0]   result,
    output logic              done
);

    localparam int unsigned N_CHUNKS = (N_BITS + 1 + CHUNK_W - 1) / CHUNK_W;
    localparam int unsigned EXT_W    = N_CHUNKS * CHUNK_W;
    localparam int unsigned CNT_W    = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [EXT_W-1:0]   a_q;        // operand A, shifted down one limb per RUN cycle
    logic [EXT_W-1:0]   b_q;        // operand B (inverted for subtract), shifted likewise
    logic [EXT_W-1:0]   res_q;      // result limbs shift in from the top
    logic               carry_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               done_q;
    logic [CHUNK_W:0]   chunk_sum;

    // Current limb sum: lowest limb of each operand plus the rippling carry.
    always_comb begin
        chunk_sum = {1'b0, a_q[CHUNK_W-1:0]}
                  + {1'b0, b_q[CHUNK_W-1:0]}
                  + (CHUNK_W + 1)'(carry_q);
    end

    // Control FSM and datapath registers. After N_CHUNKS shifts, limb i of the
    // sum sits at result chunk i; the carry out of the top limb is discarded.
    always_ff @(posedge clk) begin
        if (resetn) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_q     <= EXT_W'(in_a);
                        b_q     <= subtract ? ~EXT_W'(in_b) : EXT_W'(in_b);
                        carry_q <= subtract;
                        cnt_q   <= '0;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    res_q   <= {chunk_sum[CHUNK_W-1:0], res_q[EXT_W-1:CHUNK_W]};
                    a_q     <= a_q >> CHUNK_W;
                    b_q     <= b_q >> CHUNK_W;
                    carry_q <= chunk_sum[CHUNK_W];
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(N_CHUNKS - 1)) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign result = res_q[N_BITS:0];
    assign done   = done_q;

endmodule

// File: tb/tb_mp_adder.sv
// Self-checking bench for mp_adder: directed corner cases plus random operands
// compared against plain wide-integer arithmetic.
module tb_mp_adder;

    localparam int unsigned N   = 1027;
    localparam int unsigned R   = 1028;
    localparam int          LAT = 10;

    logic         clk = 1'b0;
    logic         resetn = 1'b1;
    logic         start = 1'b0;
    logic         subtract = 1'b0;
    logic [N-1:0] in_a = '0;
    logic [N-1:0] in_b = '0;
    logic [R-1:0] result;
    logic         done;

    int total = 0;
    int bad   = 0;

    mp_adder dut (
        .clk      (clk),
        .resetn   (resetn),
        .start    (start),
        .subtract (subtract),
        .in_a     (in_a),
        .in_b     (in_b),
        .result   (result),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Compare one observed value against its expectation.
    task automatic check_eq(input string tag, input logic [R-1:0] got, input logic [R-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h..%h exp=%h..%h diffbits=%0d", tag,
                     got[R-1:R-4], got[95:0], exp[R-1:R-4], exp[95:0], $countones(got ^ exp));
        end
    endtask

    // Random value with only the low nbits possibly set.
    function automatic logic [N-1:0] rand_wide(input int unsigned nbits);
        logic [N-1:0] v;
        logic [N-1:0] m;
        v = '0;
        for (int i = 0; i < 33; i++) v = {v[N-33:0], 32'($urandom)};
        m = '1;
        m = m >> (N - nbits);
        return v & m;
    endfunction

    function automatic logic [R-1:0] golden(input logic [N-1:0] a, input logic [N-1:0] b, input logic sub);
        logic [R-1:0] ea;
        logic [R-1:0] eb;
        ea = R'(a);
        eb = R'(b);
        return sub ? (ea - eb) : (ea + eb);
    endfunction

    // Issue one operation, check latency, result and single-cycle done.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic sub,
                          input bit garble, input string tag);
        logic [R-1:0] exp;
        int lat;
        exp = golden(a, b, sub);
        @(negedge clk);
        start = 1'b1; subtract = sub; in_a = a; in_b = b;
        @(negedge clk);
        start = 1'b0;
        if (garble) begin
            in_a = rand_wide(N); in_b = rand_wide(N); subtract = ~sub;
        end
        lat = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check_eq({tag, "_lat"}, R'(lat), R'(LAT));
        check_eq({tag, "_res"}, result, exp);
        @(negedge clk);
        check_eq({tag, "_done_pulse"}, R'(done), R'(0));
    endtask

    initial begin
        logic [R-1:0] exp;
        logic [R-1:0] hold;
        logic [N-1:0] a;
        logic [N-1:0] b;
        int cnt;
        int lat;

        // Reset held two cycles, then idle with start low.
        repeat (2) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        check_eq("rst_result", result, '0);
        check_eq("rst_done", R'(done), R'(0));
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) cnt++;
        end
        check_eq("idle_no_done", R'(cnt), R'(0));

        // Small add, then result must hold.
        run_op(N'(1000), N'(2000), 1'b0, 1'b0, "add_small");
        repeat (4) @(negedge clk);
        check_eq("hold_result", result, R'(3000));

        // Subtract with and without borrow.
        run_op(N'(3000), N'(1500), 1'b1, 1'b0, "sub_pos");
        check_eq("sub_pos_sign", R'(result[R-1]), R'(0));
        run_op(N'(1500), N'(3000), 1'b1, 1'b0, "sub_neg");
        check_eq("sub_neg_sign", R'(result[R-1]), R'(1));
        exp = '0;
        exp = exp - R'(1500);
        check_eq("sub_neg_val", result, exp);

        // Carry through every chunk boundary; borrow through every bit.
        a = '1;
        run_op(a, a, 1'b0, 1'b0, "add_max");
        exp = '1;
        exp = exp - R'(1);
        check_eq("add_max_val", result, exp);
        run_op(N'(0), N'(1), 1'b1, 1'b0, "sub_0_1");
        exp = '1;
        check_eq("sub_0_1_ones", result, exp);

        // Random 1024-bit operands, inputs garbled after the start cycle.
        for (int i = 0; i < 2; i++) begin
            a = rand_wide(1024);
            b = rand_wide(1024);
            run_op(a, b, 1'b0, 1'b1, "rand_add");
            run_op(a, b, 1'b1, 1'b1, "rand_sub");
        end

        // start re-asserted during RUN is ignored.
        a = rand_wide(1024);
        b = rand_wide(1024);
        exp = golden(a, b, 1'b0);
        @(negedge clk);
        start = 1'b1; subtract = 1'b0; in_a = a; in_b = b;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        lat = 0;
        hold = '0;
        for (int i = 1; i <= 25; i++) begin
            if (i == 3) begin
                start = 1'b1; subtract = 1'b1; in_a = rand_wide(N); in_b = rand_wide(N);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (done) begin
                cnt++;
                if (lat == 0) begin
                    lat = i;
                    hold = result;
                end
            end
        end
        check_eq("restart_done_count", R'(cnt), R'(1));
        check_eq("restart_lat", R'(lat), R'(LAT));
        check_eq("restart_res", hold, exp);

        // Reset during RUN aborts: result cleared, no done.
        @(negedge clk);
        start = 1'b1; subtract = 1'b0; in_a = rand_wide(1024); in_b = rand_wide(1024);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        resetn = 1'b0;
        check_eq("abort_result", result, '0);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) cnt++;
        end
        check_eq("abort_no_done", R'(cnt), R'(0));

        // Normal operation after reset.
        a = rand_wide(N);
        b = rand_wide(N);
        run_op(a, b, 1'b1, 1'b0, "post_rst_sub");
        run_op(a, b, 1'b0, 1'b0, "post_rst_add");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Guard against a hung run.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
